adc_sample_capture: RTL and testbench
=====================================

// Module: adc_sample_capture
// PURPOSE
//  FIFO-side consumer of packed ADC sample words: pops 32-bit words from the sample FIFO and unpacks one channel.
//  Waits for a rising-edge trigger against a threshold, then writes DEPTH consecutive 8-bit samples into the scope
//  frame buffer. Sits between the sample FIFO read port and the display frame-buffer write port.
// PARAMETERS
//  ADDR_W  9  frame-buffer address width; DEPTH = 2**ADDR_W samples per capture
//  CH_SEL  0  channel captured: 0 = A (word[29:16]), 1 = B (word[13:0])
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  rst        in   1       asynchronous reset, active-low
//  empty      in   1       FIFO empty flag
//  dout       in   32      FIFO read data, valid the cycle after rd_en (standard mode, not FWFT)
//  rd_en      out  1       FIFO pop request
//  arm        in   1       single-cycle pulse: start a capture (honoured in IDLE and DONE only)
//  threshold  in   14      signed two's-complement trigger level, latched on accepted arm
//  buf_we     out  1       frame-buffer write strobe
//  buf_addr   out  ADDR_W  frame-buffer write address
//  buf_data   out  8       frame-buffer write data, offset binary
//  capturing  out  1       high in WAIT_TRIG and CAPTURE
//  done       out  1       high in DONE
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; rd_en, buf_we, capturing, done = 0; buf_addr = 0; buf_data = 0; all counters = 0.
//  Reset mid-capture aborts immediately. No partial-frame flag. Frame-buffer content is don't-care.
//  Word format: ch A = dout[29:16], ch B = dout[13:0], both 14-bit two's complement. Bits 31:30 and 15:14 are ignored.
//  Conversion: s = selected 14-bit sample; buf_data = {~s[13], s[12:6]}, e.g. -8192 -> 0x00, 0 -> 0x80, 8191 -> 0xFF.
//  FIFO handshake:
//   - rd_en is never asserted while empty = 1.
//   - vld <= rd_en; dout is consumed only in cycles where vld = 1.
//   - At most one read is outstanding at a time; back-to-back reads are allowed (one pop per cycle).
//  States:
//   IDLE:      rd_en = 0. On arm: latch threshold, clear prev_valid -> WAIT_TRIG.
//   WAIT_TRIG: rd_en = !empty. For each vld sample s:
//              - if prev_valid && prev < thr && s >= thr (signed), it is the trigger.
//              - otherwise prev <= s and prev_valid <= 1.
//              - The first sample after arm never triggers.
//              On trigger:
//              - write s at addr 0 (buf_we = 1 next cycle, registered output);
//              - req_cnt <= 1 + rd_en(this cycle), counting the in-flight read as sample 1;
//              - -> CAPTURE.
//   CAPTURE:   rd_en = !empty && req_cnt < DEPTH; req_cnt increments on each rd_en.
//              Each vld sample is written at the next address (addr increments by 1 per write, no gaps).
//              When the write at addr DEPTH-1 is issued -> DONE.
//              Exactly DEPTH words are popped from the trigger word onward; no extra word is ever popped.
//   DONE:      done = 1, rd_en = 0, FIFO untouched. On arm -> WAIT_TRIG; done clears the next cycle.
//  arm in WAIT_TRIG or CAPTURE is ignored.
//  Latency: FIFO word to buf_we is 2 cycles (rd_en -> vld -> registered write).
//  buf_addr wraps naturally at DEPTH, but DONE is entered before any wrap occurs.
//  Samples arriving while empty toggles are written contiguously and in FIFO order.
// TESTING
//  1 Hold rst = 0 with random inputs -> every output 0; release -> IDLE, rd_en stays 0 with FIFO non-empty.
//  2 CH_SEL = 0, thr = 0, FIFO ch A ramp -4 .. +600 step 1, arm:
//    -> trigger at s = 0, buf_addr 0 data 0x80; 512 writes of s = 0..511 at addr 0..511; done = 1; exactly 512 pops after trigger.
//  3 Same as 2 with empty toggled randomly (about 50%) -> rd_en never high with empty = 1; captured data gapless and identical to 2.
//  4 thr = 100, all samples = 200 -> no trigger, buf_we never asserted, capturing stays 1.
//    Then feed 50 followed by 150 -> trigger on 150.
//  5 Drive rst low during CAPTURE at buf_addr = 100 -> buf_we = 0 same instant, IDLE; re-arm -> next frame starts at addr 0.
//  6 arm pulse during CAPTURE -> ignored, frame completes normally; arm in DONE -> done = 0 next cycle, new capture from addr 0.

Source files
------------

// File: rtl/adc_sample_capture_if.sv
// Bundles the sample-FIFO read port and the frame-buffer write port of the
// ADC capture block. The master side is the capture block itself.
interface adc_sample_capture_if #(
    parameter int ADDR_W = 9
) ();
    // Sample FIFO read port (standard mode: dout valid the cycle after rd_en)
    logic              empty;
    logic [31:0]       dout;
    logic              rd_en;
    // Frame-buffer write port
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;

    modport master (
        input  empty,
        input  dout,
        output rd_en,
        output buf_we,
        output buf_addr,
        output buf_data
    );

    modport slave (
        output empty,
        output dout,
        input  rd_en,
        input  buf_we,
        input  buf_addr,
        input  buf_data
    );
endinterface

// File: rtl/adc_sample_capture.sv
// ADC sample capture: pops packed ADC words from the sample FIFO, unpacks one
// channel, waits for a rising crossing of a signed threshold and then writes
// 2**ADDR_W consecutive 8-bit offset-binary samples into the frame buffer.
module adc_sample_capture #(
    parameter int ADDR_W = 9,
    parameter int CH_SEL = 0
) (
    input  logic                clk,
    input  logic                rst,
    adc_sample_capture_if.master bus,
    input  logic                arm,
    input  logic signed [13:0]  threshold,
    output logic                capturing,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Request count that ends a capture, and the address of its last sample
    localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    // 14-bit two's complement to 8-bit offset binary (top 8 bits, sign flipped)
    function automatic logic [7:0] to_offset8(input logic [13:0] s);
        return {~s[13], s[12:6]};
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic               vld_r;
    logic               rd_en_s;
    logic               trig_s;
    logic signed [13:0] sample_s;
    logic signed [13:0] prev_r;
    logic               prev_valid_r;
    logic signed [13:0] thr_r;
    logic [ADDR_W:0]    req_cnt_r;
    logic [ADDR_W-1:0]  wr_addr_s;
    logic               buf_we_r;
    logic [ADDR_W-1:0]  buf_addr_r;
    logic [7:0]         buf_data_r;
    logic               capturing_r;
    logic               done_r;
    logic               unused_s;

    assign sample_s  = (CH_SEL == 0) ? bus.dout[29:16] : bus.dout[13:0];
    assign unused_s  = ^{bus.dout[31:30], bus.dout[15:14]};
    assign wr_addr_s = buf_addr_r + ADDR_ONE;

    assign bus.rd_en    = rd_en_s;
    assign bus.buf_we   = buf_we_r;
    assign bus.buf_addr = buf_addr_r;
    assign bus.buf_data = buf_data_r;
    assign capturing    = capturing_r;
    assign done         = done_r;

    // Next-state, FIFO pop request and trigger detection
    always_comb begin
        next_state_s = state_r;
        rd_en_s      = 1'b0;
        trig_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                rd_en_s = ~bus.empty;
                if (vld_r && prev_valid_r && (prev_r < thr_r) && (sample_s >= thr_r)) begin
                    trig_s       = 1'b1;
                    next_state_s = ST_CAPT;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_CAPT: begin
                rd_en_s = ~bus.empty && (req_cnt_r < DEPTH_CNT);
                if (vld_r && (wr_addr_s == LAST_ADDR)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CAPT;
                end
            end
            ST_DONE: begin
                if (arm) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, read-valid pipeline and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            vld_r       <= 1'b0;
            capturing_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            vld_r       <= rd_en_s;
            capturing_r <= (next_state_s == ST_WAIT) || (next_state_s == ST_CAPT);
            done_r      <= (next_state_s == ST_DONE);
        end
    end

    // Trigger history, request counter and frame-buffer write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_r       <= 14'sd0;
            prev_valid_r <= 1'b0;
            thr_r        <= 14'sd0;
            req_cnt_r    <= {(ADDR_W+1){1'b0}};
            buf_we_r     <= 1'b0;
            buf_addr_r   <= {ADDR_W{1'b0}};
            buf_data_r   <= 8'h00;
        end else begin
            buf_we_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        thr_r        <= threshold;
                        prev_valid_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (trig_s) begin
                        // Trigger word goes to address 0; a pop issued this
                        // cycle is already the second sample of the frame.
                        buf_we_r   <= 1'b1;
                        buf_addr_r <= {ADDR_W{1'b0}};
                        buf_data_r <= to_offset8(sample_s);
                        req_cnt_r  <= CNT_ONE + {{ADDR_W{1'b0}}, rd_en_s};
                    end else if (vld_r) begin
                        prev_r       <= sample_s;
                        prev_valid_r <= 1'b1;
                    end
                end
                ST_CAPT: begin
                    if (rd_en_s) begin
                        req_cnt_r <= req_cnt_r + CNT_ONE;
                    end
                    if (vld_r) begin
                        buf_we_r   <= 1'b1;
                        buf_addr_r <= wr_addr_s;
                        buf_data_r <= to_offset8(sample_s);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture: a queue-based standard-mode FIFO
// model feeds packed words, a recorder collects frame-buffer writes, and
// expected values come from hand-computed tables and ramp formulas.
module tb_adc_sample_capture;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic        clk;
    logic        rst;
    logic        arm;
    logic [13:0] threshold;
    logic        capturing;
    logic        done;

    adc_sample_capture_if #(.ADDR_W(ADDR_W)) bus ();

    adc_sample_capture #(.ADDR_W(ADDR_W), .CH_SEL(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .arm       (arm),
        .threshold (threshold),
        .capturing (capturing),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] fifo_q[$];
    int          pops  = 0;
    int          viol  = 0;
    bit          gate_en = 1'b0;
    int          wr_n  = 0;
    logic [8:0]  wr_a[1024];
    logic [7:0]  wr_d[1024];

    typedef struct packed {
        logic [13:0] thr;
        logic [13:0] s0;
        logic [13:0] s1;
        logic [13:0] s2;
        logic [13:0] s3;
        logic        trig;
        logic [7:0]  data;
    } vec_t;

    // Standard-mode FIFO: pop on rd_en, data appears on dout the next cycle
    always @(posedge clk) begin
        if (bus.rd_en) begin
            if (bus.empty || fifo_q.size() == 0) viol <= viol + 1;
            if (fifo_q.size() != 0) begin
                bus.dout <= fifo_q.pop_front();
                pops     <= pops + 1;
            end
        end
    end

    // Overall time limit
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_word(input logic [13:0] a);
        logic [13:0] b;
        b = ~a;
        return {2'b11, a, 2'b10, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        bus.empty = (fifo_q.size() == 0) || (gate_en && ($urandom_range(0, 1) == 1));
        @(negedge clk);
        if (bus.buf_we) begin
            if (wr_n < 1024) begin
                wr_a[wr_n] = bus.buf_addr;
                wr_d[wr_n] = bus.buf_data;
            end
            wr_n++;
        end
        bus.empty = (fifo_q.size() == 0) || (gate_en && ($urandom_range(0, 1) == 1));
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        arm     = 1'b0;
        gate_en = 1'b0;
        fifo_q.delete();
        tick();
        tick();
        rst = 1'b1;
        tick();
        wr_n = 0;
    endtask

    task automatic do_arm(input logic [13:0] thr);
        arm       = 1'b1;
        threshold = thr;
        tick();
        arm = 1'b0;
    endtask

    task automatic push_ramp(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) fifo_q.push_back(mk_word(14'(v)));
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done) break;
            tick();
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_first_write(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (wr_n > 0) break;
            tick();
        end
        check(name, {31'd0, (wr_n > 0)}, 32'd1);
    endtask

    // Frame must be 512 gapless writes of the ramp 0..511
    task automatic check_ramp_frame(input string name);
        int errs;
        errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_a[i] !== 9'(i) || wr_d[i] !== (8'h80 | 8'(i >> 6))) errs++;
        end
        check({name, "_count"}, wr_n, DEPTH);
        check({name, "_data"}, errs, 0);
    endtask

    vec_t vecs[9];

    initial begin
        int p0;
        bit hit;

        vecs[0] = '{14'd0,     -14'sd1,    14'd0,      14'd5,      14'd5,   1'b1, 8'h80};
        vecs[1] = '{14'd0,      14'd5,    -14'sd1,     14'd8191,   14'd0,   1'b1, 8'hFF};
        vecs[2] = '{-14'sd8191, -14'sd8192, -14'sd8192, -14'sd8191, 14'd0,  1'b1, 8'h00};
        vecs[3] = '{14'd100,    14'd200,   14'd200,    14'd200,    14'd200, 1'b0, 8'h00};
        vecs[4] = '{14'd0,      14'd8191, -14'sd100,  -14'sd50,    14'd300, 1'b1, 8'h84};
        vecs[5] = '{-14'sd1,   -14'sd2,   -14'sd1,     14'd0,      14'd0,   1'b1, 8'h7F};
        vecs[6] = '{14'd0,     -14'sd1,    14'd64,     14'd0,      14'd0,   1'b1, 8'h81};
        vecs[7] = '{14'd10,     14'd20,    14'd30,     14'd5,      14'd9,   1'b0, 8'h00};
        vecs[8] = '{14'd10,     14'd0,     14'd10,     14'd0,      14'd0,   1'b1, 8'h80};

        rst       = 1'b0;
        arm       = 1'b0;
        threshold = 14'd0;
        bus.empty = 1'b1;
        bus.dout  = 32'd0;

        // Reset held with random activity on the inputs
        gate_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            arm       = 1'($urandom_range(0, 1));
            threshold = 14'($urandom);
            fifo_q.push_back($urandom);
            tick();
            check("reset_outputs",
                  {13'd0, bus.rd_en, bus.buf_we, bus.buf_addr, bus.buf_data, capturing, done}, 32'd0);
        end
        arm     = 1'b0;
        gate_en = 1'b0;
        p0      = pops;
        rst     = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("idle_no_pop", {31'd0, bus.rd_en}, 32'd0);
        check("idle_pops", pops - p0, 0);
        check("idle_status", {30'd0, capturing, done}, 32'd0);

        // Trigger table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            fifo_q.push_back(mk_word(vecs[i].s0));
            fifo_q.push_back(mk_word(vecs[i].s1));
            fifo_q.push_back(mk_word(vecs[i].s2));
            fifo_q.push_back(mk_word(vecs[i].s3));
            do_arm(vecs[i].thr);
            for (int k = 0; k < 30; k++) begin
                if (wr_n > 0) break;
                tick();
            end
            check($sformatf("vec%0d_trig", i), {31'd0, (wr_n > 0)}, {31'd0, vecs[i].trig});
            check($sformatf("vec%0d_capturing", i), {31'd0, capturing}, 32'd1);
            if (vecs[i].trig) begin
                check($sformatf("vec%0d_data", i), wr_d[0], vecs[i].data);
                check($sformatf("vec%0d_addr", i), wr_a[0], 32'd0);
            end
        end

        // Full ramp capture, FIFO always ready
        do_reset();
        push_ramp(-4, 600);
        p0 = pops;
        do_arm(14'd0);
        wait_done("ramp_done", 3000);
        check("ramp_first", wr_d[0], 8'h80);
        check_ramp_frame("ramp");
        check("ramp_pops", pops - p0, 516);
        check("ramp_status", {30'd0, capturing, done}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("done_no_pop", pops - p0, 516);
        check("done_rd_en", {31'd0, bus.rd_en}, 32'd0);

        // Same ramp with empty toggling
        do_reset();
        push_ramp(-4, 600);
        gate_en = 1'b1;
        p0 = pops;
        do_arm(14'd0);
        wait_done("gated_done", 6000);
        gate_en = 1'b0;
        check_ramp_frame("gated");
        check("gated_pops", pops - p0, 516);
        check("empty_violations", viol, 0);

        // No trigger while signal stays above threshold, then crossing
        do_reset();
        for (int i = 0; i < 30; i++) fifo_q.push_back(mk_word(14'd200));
        do_arm(14'd100);
        for (int i = 0; i < 60; i++) tick();
        check("above_no_write", wr_n, 0);
        check("above_capturing", {31'd0, capturing}, 32'd1);
        fifo_q.push_back(mk_word(14'd50));
        for (int i = 0; i < 600; i++) fifo_q.push_back(mk_word(14'd150));
        wait_first_write("cross_seen", 50);
        check("cross_data", wr_d[0], 8'h82);
        check("cross_addr", wr_a[0], 32'd0);

        // Asynchronous reset in the middle of the frame
        hit = 1'b0;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (bus.buf_we && bus.buf_addr == 9'd100) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_addr100", {31'd0, hit}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_outputs",
              {20'd0, bus.rd_en, bus.buf_we, bus.buf_addr, capturing}, 32'd0);
        tick();
        rst = 1'b1;
        fifo_q.delete();
        wr_n = 0;
        tick();
        push_ramp(-4, 600);
        do_arm(14'd0);
        wait_first_write("rearm_seen", 50);
        check("rearm_addr", wr_a[0], 32'd0);
        check("rearm_data", wr_d[0], 8'h80);

        // arm during CAPTURE is ignored; arm in DONE restarts
        for (int k = 0; k < 400; k++) begin
            if (wr_n >= 200) break;
            tick();
        end
        do_arm(14'd5000);
        wait_done("armcap_done", 2000);
        check_ramp_frame("armcap");
        do_arm(14'd0);
        check("rearm_done_clear", {30'd0, capturing, done}, 32'd2);
        wr_n = 0;
        push_ramp(-4, 20);
        wait_first_write("restart_seen", 300);
        check("restart_addr", wr_a[0], 32'd0);
        check("restart_data", wr_d[0], 8'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
